// File: rtl/bomb_pkg.sv
// Shared types and default constants for the bomb fuse controller.
package bomb_pkg;

    localparam int unsigned N_SLOTS      = 4;
    localparam int unsigned FUSE_FRAMES  = 120;
    localparam int unsigned BLAST_FRAMES = 30;
    localparam int unsigned CNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BLAST = 2'd2
    } slot_state_t;

endpackage

// File: rtl/bomb_fuse_ctrl_if.sv
// Placer/renderer-facing bus of the bomb fuse controller.
interface bomb_fuse_ctrl_if;
    import bomb_pkg::*;

    logic               frame_tick;
    logic               clear;
    logic [N_SLOTS-1:0] bombstart;
    logic [N_SLOTS-1:0] chain_hit;
    logic [N_SLOTS-1:0] bomb_on;
    logic [N_SLOTS-1:0] blast_on;
    logic [N_SLOTS-1:0] explode;
    logic [N_SLOTS-1:0] fuse_msb;

    modport master (
        output frame_tick, clear, bombstart, chain_hit,
        input  bomb_on, blast_on, explode, fuse_msb
    );

    modport slave (
        input  frame_tick, clear, bombstart, chain_hit,
        output bomb_on, blast_on, explode, fuse_msb
    );

endinterface

// File: rtl/bomb_slot_fsm.sv
// One bomb slot: IDLE -> ARMED (fuse countdown) -> BLAST (blast countdown) -> IDLE.
module bomb_slot_fsm
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_FRAMES  = bomb_pkg::FUSE_FRAMES,
    parameter int unsigned BLAST_FRAMES = bomb_pkg::BLAST_FRAMES,
    parameter int unsigned CNT_W        = bomb_pkg::CNT_W
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_tick,
    input  logic clear,
    input  logic bombstart,
    input  logic chain_hit,
    output logic bomb_on,
    output logic blast_on,
    output logic explode,
    output logic fuse_msb
);

    localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_FRAMES);
    localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_FRAMES);
    localparam logic [CNT_W-1:0] FLASH_LIM  = CNT_W'(FUSE_FRAMES / 4);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    slot_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             explode_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= CNT_ZERO;
            bomb_on  <= 1'b0;
            blast_on <= 1'b0;
            explode  <= 1'b0;
            fuse_msb <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bomb_on  <= (state_nxt != IDLE);
            blast_on <= (state_nxt == BLAST);
            explode  <= explode_nxt;
            fuse_msb <= (state_nxt == ARMED) && (cnt_nxt < FLASH_LIM);
        end
    end

    // Arm/tick in one cycle only loads; a zero counter is never decremented.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        explode_nxt = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = CNT_ZERO;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bombstart) begin
                        state_nxt = ARMED;
                        cnt_nxt   = FUSE_LOAD;
                    end
                end
                ARMED: begin
                    if (chain_hit || (frame_tick && cnt == CNT_ONE)) begin
                        state_nxt   = BLAST;
                        cnt_nxt     = BLAST_LOAD;
                        explode_nxt = 1'b1;
                    end else if (frame_tick && cnt != CNT_ZERO) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                BLAST: begin
                    if (frame_tick && cnt == CNT_ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = CNT_ZERO;
                    end else if (frame_tick && cnt != CNT_ZERO) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: rtl/bomb_fuse_ctrl.sv
// Bomb-slot lifetime owner: one independent fuse/blast FSM per slot.
module bomb_fuse_ctrl
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_FRAMES  = bomb_pkg::FUSE_FRAMES,
    parameter int unsigned BLAST_FRAMES = bomb_pkg::BLAST_FRAMES,
    parameter int unsigned CNT_W        = bomb_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    bomb_fuse_ctrl_if.slave  bus
);

    logic [N_SLOTS-1:0] bomb_on;
    logic [N_SLOTS-1:0] blast_on;
    logic [N_SLOTS-1:0] explode;
    logic [N_SLOTS-1:0] fuse_msb;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        bomb_slot_fsm #(
            .FUSE_FRAMES  (FUSE_FRAMES),
            .BLAST_FRAMES (BLAST_FRAMES),
            .CNT_W        (CNT_W)
        ) u_slot (
            .Clk        (Clk),
            .Reset      (Reset),
            .frame_tick (bus.frame_tick),
            .clear      (bus.clear),
            .bombstart  (bus.bombstart[i]),
            .chain_hit  (bus.chain_hit[i]),
            .bomb_on    (bomb_on[i]),
            .blast_on   (blast_on[i]),
            .explode    (explode[i]),
            .fuse_msb   (fuse_msb[i])
        );
    end

    assign bus.bomb_on  = bomb_on;
    assign bus.blast_on = blast_on;
    assign bus.explode  = explode;
    assign bus.fuse_msb = fuse_msb;

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Self-checking bench for bomb_fuse_ctrl: vector table, corner sequences, random run vs deadline model.
module tb_bomb_fuse_ctrl;
    import bomb_pkg::*;

    localparam int unsigned NS   = N_SLOTS;
    localparam int unsigned FUSE = FUSE_FRAMES;
    localparam int unsigned BL   = BLAST_FRAMES;

    logic Clk = 1'b0;
    logic Reset;

    bomb_fuse_ctrl_if bus();

    bomb_fuse_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: absolute tick deadlines per slot instead of countdowns.
    int      ph   [NS];
    longint  det  [NS];
    longint  endt [NS];
    longint  g = 0;
    logic [NS-1:0] m_bomb, m_blast, m_expl, m_msb;

    typedef struct {
        logic          tick;
        logic          clr;
        logic [NS-1:0] bs;
        logic [NS-1:0] ch;
        logic [NS-1:0] e_bomb;
        logic [NS-1:0] e_blast;
        logic [NS-1:0] e_expl;
        logic [NS-1:0] e_msb;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) ph[i] = 0;
        m_bomb = '0; m_blast = '0; m_expl = '0; m_msb = '0;
    endfunction

    function automatic void model_step(input logic tick, input logic clr,
                                       input logic [NS-1:0] bs, input logic [NS-1:0] ch);
        g += longint'(tick);
        m_expl = '0;
        for (int i = 0; i < NS; i++) begin
            if (clr) ph[i] = 0;
            else if (ph[i] == 0) begin
                if (bs[i]) begin ph[i] = 1; det[i] = g + longint'(FUSE); end
            end else if (ph[i] == 1) begin
                if (ch[i] || (tick && g == det[i])) begin
                    ph[i] = 2; endt[i] = g + longint'(BL); m_expl[i] = 1'b1;
                end
            end else begin
                if (tick && g == endt[i]) ph[i] = 0;
            end
            m_bomb[i]  = (ph[i] != 0);
            m_blast[i] = (ph[i] == 2);
            m_msb[i]   = (ph[i] == 1) && ((det[i] - g) < longint'(FUSE / 4));
        end
    endfunction

    // One clock: drive inputs, step model on the edge, compare just after it.
    task automatic cyc(input logic tick, input logic clr,
                       input logic [NS-1:0] bs, input logic [NS-1:0] ch);
        bus.frame_tick = tick;
        bus.clear      = clr;
        bus.bombstart  = bs;
        bus.chain_hit  = ch;
        @(posedge Clk);
        model_step(tick, clr, bs, ch);
        #1;
        check("bomb_on",  bus.bomb_on,  m_bomb);
        check("blast_on", bus.blast_on, m_blast);
        check("explode",  bus.explode,  m_expl);
        check("fuse_msb", bus.fuse_msb, m_msb);
    endtask

    task automatic do_reset();
        Reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.clear      = 1'b0;
        bus.bombstart  = '0;
        bus.chain_hit  = '0;
        model_reset();
        @(posedge Clk);
        #1;
        check("reset_bomb_on",  bus.bomb_on,  '0);
        check("reset_blast_on", bus.blast_on, '0);
        check("reset_explode",  bus.explode,  '0);
        check("reset_fuse_msb", bus.fuse_msb, '0);
        Reset = 1'b0;
    endtask

    initial begin
        int x0, x1, on0, on2, cnt_e, blast_n, last_on;
        logic [NS-1:0] seen, bs_r, ch_r;

        tbl[0] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        tbl[4] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        tbl[5] = '{1'b1, 1'b1, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[6] = '{1'b0, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        tbl[7] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        do_reset();

        // Vector table: arm, arm+tick, ignored chain, chain blast, ignored re-arm, clear.
        for (int v = 0; v < 8; v++) begin
            cyc(tbl[v].tick, tbl[v].clr, tbl[v].bs, tbl[v].ch);
            check($sformatf("tbl%0d_bomb_on", v),  bus.bomb_on,  tbl[v].e_bomb);
            check($sformatf("tbl%0d_blast_on", v), bus.blast_on, tbl[v].e_blast);
            check($sformatf("tbl%0d_explode", v),  bus.explode,  tbl[v].e_expl);
            check($sformatf("tbl%0d_fuse_msb", v), bus.fuse_msb, tbl[v].e_msb);
        end

        // Idle for 200 ticks: nothing moves.
        do_reset();
        seen = '0;
        for (int k = 0; k < 200; k++) begin
            cyc(1'b1, 1'b0, '0, '0);
            seen |= bus.bomb_on | bus.blast_on | bus.explode | bus.fuse_msb;
        end
        check("idle_any_output", seen, '0);

        // Single arm of slot 0: full fuse then blast.
        do_reset();
        cyc(1'b0, 1'b0, 4'b0001, '0);
        check("arm_latency", bus.bomb_on, 4'b0001);
        cnt_e = 0; x0 = -1; blast_n = 0; last_on = -1;
        for (int k = 1; k <= 160; k++) begin
            cyc(1'b1, 1'b0, '0, '0);
            if (bus.explode[0]) begin cnt_e++; x0 = k; end
            if (bus.blast_on[0]) blast_n++;
            if (bus.bomb_on[0]) last_on = k;
            cyc(1'b0, 1'b0, '0, '0);
            if (bus.explode[0]) cnt_e++;
        end
        check_int("single_explode_count", cnt_e, 1);
        check_int("single_explode_tick", x0, int'(FUSE));
        check_int("single_blast_ticks", blast_n, int'(BL));
        check_int("single_last_on_tick", last_on, int'(FUSE + BL) - 1);

        // bombstart[1] held: re-arm only after each return to IDLE.
        do_reset();
        cnt_e = 0; x0 = -1; x1 = -1;
        cyc(1'b0, 1'b0, 4'b0010, '0);
        for (int k = 1; k <= 300; k++) begin
            cyc(1'b1, 1'b0, 4'b0010, '0);
            if (bus.explode[1]) begin
                cnt_e++;
                if (x0 < 0) x0 = k; else x1 = k;
            end
            cyc(1'b0, 1'b0, 4'b0010, '0);
            if (bus.explode[1]) cnt_e++;
        end
        check_int("held_explode_count", cnt_e, 2);
        check_int("held_first_explode", x0, int'(FUSE));
        check_int("held_second_explode", x1, int'(2 * FUSE + BL));

        // Chain: slot 2 armed 10 ticks late, pulled in by slot 0's blast.
        do_reset();
        x0 = -1; on0 = -1; on2 = -1;
        cyc(1'b0, 1'b0, 4'b0001, '0);
        for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 4'b0100, '0);
        for (int k = 11; k <= 160; k++) begin
            cyc(1'b1, 1'b0, '0, '0);
            if (bus.bomb_on[0]) on0 = k;
            if (bus.bomb_on[2]) on2 = k;
            if (bus.explode[0]) begin
                x0 = k;
                cyc(1'b0, 1'b0, '0, 4'b0100);
                check("chain_explode", bus.explode, 4'b0100);
            end
        end
        check_int("chain_src_explode_tick", x0, int'(FUSE));
        check_int("chain_slot0_last_on", on0, int'(FUSE + BL) - 1);
        check_int("chain_slot2_last_on", on2, int'(FUSE + BL) - 1);

        // Reset mid-fuse: immediate clear, then a fresh full fuse.
        do_reset();
        cyc(1'b0, 1'b0, 4'b1000, '0);
        for (int k = 1; k <= 60; k++) cyc(1'b1, 1'b0, '0, '0);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_bomb_on", bus.bomb_on, '0);
        check("async_reset_fuse_msb", bus.fuse_msb | bus.blast_on, '0);
        model_reset();
        seen = '0;
        repeat (3) begin @(posedge Clk); #1 seen |= bus.explode; end
        check("async_reset_explode", seen, '0);
        Reset = 1'b0;
        cyc(1'b0, 1'b0, 4'b1000, '0);
        x0 = -1;
        for (int k = 1; k <= 130; k++) begin
            cyc(1'b1, 1'b0, '0, '0);
            if (bus.explode[3]) x0 = k;
        end
        check_int("rearm_after_reset_explode", x0, int'(FUSE));

        // All four armed with a tick, no clear: simultaneous explode.
        do_reset();
        cnt_e = 0; x0 = -1;
        cyc(1'b1, 1'b0, 4'b1111, '0);
        for (int k = 1; k <= 125; k++) begin
            cyc(1'b1, 1'b0, '0, '0);
            if (bus.explode != '0) begin
                cnt_e++; x0 = k;
                check("all_explode_together", bus.explode, 4'b1111);
            end
        end
        check_int("all_explode_events", cnt_e, 1);
        check_int("all_explode_tick", x0, int'(FUSE));

        // Same, with clear at tick 50: everything drops, no explode ever.
        do_reset();
        cyc(1'b1, 1'b0, 4'b1111, '0);
        for (int k = 1; k <= 50; k++) cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, '0, 4'b1111);
        check("clear_bomb_on", bus.bomb_on, '0);
        check("clear_explode", bus.explode, '0);
        seen = '0;
        for (int k = 0; k < 100; k++) begin
            cyc(1'b1, 1'b0, '0, '0);
            seen |= bus.explode | bus.bomb_on;
        end
        check("after_clear_quiet", seen, '0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NS; i++) begin
                bs_r[i] = ($urandom_range(0, 7) == 0);
                ch_r[i] = ($urandom_range(0, 19) == 0);
            end
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 599) == 0), bs_r, ch_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
